nibble_fetch: RTL and testbench

Instruction fetch stage of the 4-bit core. Holds the 12-bit program counter, addresses program ROM, captures the returned byte into an instruction register and splits it into opcode and operand nibbles. Alternates FETCH and EXECUTE phases. Feeds the downstream decode and flip-flop register stage, which samples instr/oprnd during EXECUTE.

---
 rtl/nibble_fetch_if.sv | 34 +++
 rtl/nibble_fetch.sv | 67 ++++++
 tb/tb_nibble_fetch.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/nibble_fetch_if.sv
// ============================================================================
//  Module   : nibble_fetch_if
//  Brief    : Bus between the fetch stage and its sequencer, ROM and decoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nibble_fetch_if #(
  parameter int PC_W = 12,
  parameter int IR_W = 8
);
  logic              en;
  logic              load_pc;
  logic [PC_W-1:0]   pc_in;
  logic [IR_W-1:0]   rom_data;
  logic [PC_W-1:0]   pc_out;
  logic [IR_W/2-1:0] instr;
  logic [IR_W/2-1:0] oprnd;
  logic              phase;
  logic              exec_start;

  // Master drives control and ROM data; the fetch stage is the slave.
  modport master (
    output en, load_pc, pc_in, rom_data,
    input  pc_out, instr, oprnd, phase, exec_start
  );

  modport slave (
    input  en, load_pc, pc_in, rom_data,
    output pc_out, instr, oprnd, phase, exec_start
  );
endinterface

`default_nettype wire

// File: rtl/nibble_fetch.sv
// ============================================================================
//  Module   : nibble_fetch
//  Brief    : Fetch stage of the 4-bit core: PC, ROM capture, opcode/operand split.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_fetch #(
  parameter int PC_W = 12,
  parameter int IR_W = 8
) (
  input  wire logic        clk,
  input  wire logic        Rst,
  nibble_fetch_if.slave    bus
);

  localparam int HALF = IR_W / 2;

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [IR_W-1:0]   r_ir;
  logic              r_exec_start;

  // pc_in and rom_data are only sampled in the state that consumes them,
  // so unknowns on those buses never reach the registers.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_state      <= S_FETCH;
      r_pc         <= '0;
      r_ir         <= '0;
      r_exec_start <= 1'b0;
    end else begin
      r_exec_start <= 1'b0;
      if (bus.en) begin
        case (r_state)
          S_FETCH: begin
            r_ir         <= bus.rom_data;
            r_pc         <= r_pc + PC_W'(1);
            r_state      <= S_EXEC;
            r_exec_start <= 1'b1;
          end
          S_EXEC: begin
            if (bus.load_pc) begin
              r_pc <= bus.pc_in;
            end
            r_state <= S_FETCH;
          end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

  assign bus.pc_out     = r_pc;
  assign bus.instr      = r_ir[IR_W-1:HALF];
  assign bus.oprnd      = r_ir[HALF-1:0];
  assign bus.phase      = r_state;
  assign bus.exec_start = r_exec_start;

endmodule

`default_nettype wire

// File: tb/tb_nibble_fetch.sv
// ============================================================================
//  Module   : tb_nibble_fetch
//  Brief    : Directed self-checking bench for nibble_fetch.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_fetch;

  logic clk;
  logic Rst;
  logic [7:0] rom [0:4095];
  int n_cmp;
  int n_fail;

  nibble_fetch_if #(.PC_W(12), .IR_W(8)) bus ();

  nibble_fetch #(.PC_W(12), .IR_W(8)) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  assign bus.rom_data = rom[bus.pc_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [11:0] pc, input logic [3:0] ins,
                         input logic [3:0] opr, input logic ph, input logic es);
    chk({tag, ".pc"},    16'(bus.pc_out),     16'(pc));
    chk({tag, ".instr"}, 16'(bus.instr),      16'(ins));
    chk({tag, ".oprnd"}, 16'(bus.oprnd),      16'(opr));
    chk({tag, ".phase"}, 16'(bus.phase),      16'(ph));
    chk({tag, ".estart"}, 16'(bus.exec_start), 16'(es));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'(i);
    rom[12'h000] = 8'hA3;
    rom[12'h001] = 8'h5C;
    rom[12'h123] = 8'h7E;
    rom[12'hFFF] = 8'h11;

    Rst         = 1'b0;
    bus.en      = 1'b1;
    bus.load_pc = 1'b0;
    bus.pc_in   = '0;

    #3;
    chk_all("rst_async", 12'h000, 4'h0, 4'h0, 1'b0, 1'b0);
    #3;  // t=6: one edge passed while held in reset
    chk_all("rst_hold", 12'h000, 4'h0, 4'h0, 1'b0, 1'b0);
    #4;
    Rst = 1'b1;  // released at t=10, between edges

    step();
    chk_all("run_e1", 12'h001, 4'hA, 4'h3, 1'b1, 1'b1);
    step();
    chk_all("run_e2", 12'h001, 4'hA, 4'h3, 1'b0, 1'b0);
    step();
    chk_all("run_e3", 12'h002, 4'h5, 4'hC, 1'b1, 1'b1);

    // Jump from EXECUTE
    bus.load_pc = 1'b1;
    bus.pc_in   = 12'h123;
    step();
    chk_all("jmp_exec", 12'h123, 4'h5, 4'hC, 1'b0, 1'b0);
    bus.load_pc = 1'b0;
    bus.pc_in   = 'x;
    step();
    chk_all("jmp_fetch", 12'h124, 4'h7, 4'hE, 1'b1, 1'b1);

    // load_pc must be ignored while fetching at pc=4
    bus.load_pc = 1'b1;
    bus.pc_in   = 12'h004;
    step();
    chk("to4.pc", 16'(bus.pc_out), 16'h0004);
    bus.pc_in   = 12'h0F0;
    step();
    chk_all("ign_fetch", 12'h005, 4'h0, 4'h4, 1'b1, 1'b1);
    bus.load_pc = 1'b0;

    // Wrap at top of address space
    bus.load_pc = 1'b1;
    bus.pc_in   = 12'hFFF;
    step();
    chk("wrap_jmp.pc", 16'(bus.pc_out), 16'h0FFF);
    bus.load_pc = 1'b0;
    bus.pc_in   = 'x;
    step();
    chk_all("wrap", 12'h000, 4'h1, 4'h1, 1'b1, 1'b1);

    // Stall in EXECUTE for three edges
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all("stall", 12'h000, 4'h1, 4'h1, 1'b1, 1'b0);
    end
    bus.en = 1'b1;
    step();
    chk_all("resume_exec", 12'h000, 4'h1, 4'h1, 1'b0, 1'b0);
    step();
    chk_all("resume_fetch", 12'h001, 4'hA, 4'h3, 1'b1, 1'b1);

    // Reach pc=0x045 in EXECUTE, then reset between edges
    bus.load_pc = 1'b1;
    bus.pc_in   = 12'h044;
    step();
    bus.load_pc = 1'b0;
    step();
    chk_all("pre_rst", 12'h045, 4'h4, 4'h4, 1'b1, 1'b1);
    #2;
    bus.load_pc = 1'b1;
    bus.pc_in   = 12'h3C3;
    Rst         = 1'b0;
    #1;
    chk_all("rst_mid", 12'h000, 4'h0, 4'h0, 1'b0, 1'b0);
    step();
    chk_all("rst_mid_hold", 12'h000, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    Rst         = 1'b1;
    bus.load_pc = 1'b0;
    step();
    chk_all("post_rst", 12'h001, 4'hA, 4'h3, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
